// File: rtl/ervp_counter_pkg.sv
// rtl/ervp_counter_pkg.sv - shared constants and helpers for the reconfigurable up/down counters
package ervp_counter_pkg;

  localparam int COUNT_MODE_SATURATE = 0;
  localparam int COUNT_MODE_CIRCULAR = 1;

  function automatic int default_top(input int bw);
    return (1 << bw) - 1;
  endfunction

endpackage

// File: rtl/ervp_sat_sub.sv
// rtl/ervp_sat_sub.sv - unsigned subtract that saturates at a floor and flags the hit
module ervp_sat_sub
  import ervp_counter_pkg::*;
#(
  parameter int             BW      = 8,
  parameter int             BW_STEP = BW,
  parameter logic [BW-1:0]  FLOOR   = '0
) (
  input  logic [BW-1:0]      minuend,
  input  logic [BW_STEP-1:0] step,
  output logic [BW-1:0]      result,
  output logic               hit
);

  logic [BW:0] diff;

  // The extra MSB catches a borrow, so values below the floor never wrap around.
  assign diff   = {1'b0, minuend} - (BW+1)'(step);
  assign hit    = diff[BW] || (diff[BW-1:0] <= FLOOR);
  assign result = hit ? FLOOR : diff[BW-1:0];

endmodule

// File: rtl/ervp_reconfigurable_down_counter.sv
// rtl/ervp_reconfigurable_down_counter.sv - run-time-step down-counter with floor saturate or reload
module ervp_reconfigurable_down_counter
  import ervp_counter_pkg::*;
#(
  parameter int BW_COUNTER      = 8,
  parameter int BW_COUNT_AMOUNT = BW_COUNTER,
  parameter int RESET_NUMBER    = default_top(BW_COUNTER),
  parameter int FIRST_NUMBER    = RESET_NUMBER,
  parameter int LAST_NUMBER     = 0,
  parameter int CIRCULAR        = COUNT_MODE_SATURATE
) (
  input  logic                       clk,
  input  logic                       rstp,
  input  logic                       enable,
  input  logic                       init,
  input  logic                       write,
  input  logic [BW_COUNTER-1:0]      wvalue,
  input  logic                       count,
  input  logic [BW_COUNT_AMOUNT-1:0] count_amount,
  output logic [BW_COUNTER-1:0]      value,
  output logic                       is_first_count,
  output logic                       is_last_count,
  output logic                       reach_pulse,
  output logic                       wrap_pulse,
  output logic                       expired
);

  localparam logic [BW_COUNTER-1:0] RESET_V = BW_COUNTER'(RESET_NUMBER);
  localparam logic [BW_COUNTER-1:0] FIRST_V = BW_COUNTER'(FIRST_NUMBER);
  localparam logic [BW_COUNTER-1:0] LAST_V  = BW_COUNTER'(LAST_NUMBER);

  logic [BW_COUNTER-1:0] sub_result;
  logic                  sub_hit;

  ervp_sat_sub #(
    .BW      (BW_COUNTER),
    .BW_STEP (BW_COUNT_AMOUNT),
    .FLOOR   (LAST_V)
  ) i_sat_sub (
    .minuend (value),
    .step    (count_amount),
    .result  (sub_result),
    .hit     (sub_hit)
  );

  assign is_first_count = (value == FIRST_V);
  assign is_last_count  = (value == LAST_V);

  always_ff @(posedge clk) begin
    if (rstp) begin
      value       <= RESET_V;
      reach_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      expired     <= 1'b0;
    end else if (!enable) begin
      reach_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      reach_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      if (init) begin
        value   <= RESET_V;
        expired <= 1'b0;
      end else if (write) begin
        value   <= wvalue;
        expired <= 1'b0;
      end else if (count && (|count_amount)) begin
        // Sitting on the floor: only a circular counter moves, and it reloads rather than reaching.
        if (value == LAST_V) begin
          if (CIRCULAR == COUNT_MODE_CIRCULAR) begin
            value      <= FIRST_V;
            wrap_pulse <= 1'b1;
          end
        end else if (sub_hit) begin
          value       <= LAST_V;
          reach_pulse <= 1'b1;
          expired     <= 1'b1;
        end else begin
          value <= sub_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_ervp_reconfigurable_down_counter.sv
// tb/tb_ervp_reconfigurable_down_counter.sv - randomized and directed checks of the down-counter
module tb_ervp_reconfigurable_down_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8-bit defaults, saturating at 0, top 255
  logic       a_rst, a_en, a_ini, a_wr, a_cnt;
  logic [7:0] a_wv, a_amt, a_value;
  logic       a_first, a_last, a_reach, a_wrap, a_exp;

  // Instance B: 4-bit, floor 3, top 9, circular
  logic       b_rst, b_en, b_ini, b_wr, b_cnt;
  logic [3:0] b_wv, b_amt, b_value;
  logic       b_first, b_last, b_reach, b_wrap, b_exp;

  ervp_reconfigurable_down_counter dut_a (
    .clk(clk), .rstp(a_rst), .enable(a_en), .init(a_ini), .write(a_wr),
    .wvalue(a_wv), .count(a_cnt), .count_amount(a_amt), .value(a_value),
    .is_first_count(a_first), .is_last_count(a_last), .reach_pulse(a_reach),
    .wrap_pulse(a_wrap), .expired(a_exp)
  );

  ervp_reconfigurable_down_counter #(
    .BW_COUNTER(4), .BW_COUNT_AMOUNT(4), .RESET_NUMBER(9),
    .FIRST_NUMBER(9), .LAST_NUMBER(3), .CIRCULAR(1)
  ) dut_b (
    .clk(clk), .rstp(b_rst), .enable(b_en), .init(b_ini), .write(b_wr),
    .wvalue(b_wv), .count(b_cnt), .count_amount(b_amt), .value(b_value),
    .is_first_count(b_first), .is_last_count(b_last), .reach_pulse(b_reach),
    .wrap_pulse(b_wrap), .expired(b_exp)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference model: plain integer arithmetic over the counter rules
  int a_mv, b_mv;
  bit a_mexp, b_mexp, a_mrp, b_mrp, a_mwp, b_mwp;
  bit a_ok = 0, b_ok = 0;

  task automatic model_step(input int first, input int last, input int rst_num, input bit circ,
                            input bit rst, input bit en, input bit ini, input bit wr, input bit cnt,
                            input int wv, input int amt,
                            inout int v, inout bit ex, output bit rp, output bit wp);
    rp = 0;
    wp = 0;
    if (rst) begin
      v = rst_num; ex = 0;
    end else if (!en) begin
      // hold
    end else if (ini) begin
      v = rst_num; ex = 0;
    end else if (wr) begin
      v = wv; ex = 0;
    end else if (cnt && amt != 0) begin
      if (v == last) begin
        if (circ) begin v = first; wp = 1; end
      end else if (v - amt <= last) begin
        v = last; rp = 1; ex = 1;
      end else begin
        v = v - amt;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(255, 0, 255, 0, a_rst, a_en, a_ini, a_wr, a_cnt, int'(a_wv), int'(a_amt),
               a_mv, a_mexp, a_mrp, a_mwp);
    model_step(9, 3, 9, 1, b_rst, b_en, b_ini, b_wr, b_cnt, int'(b_wv), int'(b_amt),
               b_mv, b_mexp, b_mrp, b_mwp);
    if (a_rst) a_ok = 1;
    if (b_rst) b_ok = 1;
  end

  always @(negedge clk) begin
    if (a_ok) begin
      chk("a_value", int'(a_value), a_mv);
      chk("a_is_first", int'(a_first), int'(a_mv == 255));
      chk("a_is_last", int'(a_last), int'(a_mv == 0));
      chk("a_reach", int'(a_reach), int'(a_mrp));
      chk("a_wrap", int'(a_wrap), int'(a_mwp));
      chk("a_expired", int'(a_exp), int'(a_mexp));
    end
    if (b_ok) begin
      chk("b_value", int'(b_value), b_mv);
      chk("b_is_first", int'(b_first), int'(b_mv == 9));
      chk("b_is_last", int'(b_last), int'(b_mv == 3));
      chk("b_reach", int'(b_reach), int'(b_mrp));
      chk("b_wrap", int'(b_wrap), int'(b_mwp));
      chk("b_expired", int'(b_exp), int'(b_mexp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cyc(input logic rst, input logic en, input logic ini, input logic wr,
                       input logic [7:0] wv, input logic cnt, input logic [7:0] amt);
    a_rst = rst; a_en = en; a_ini = ini; a_wr = wr; a_wv = wv; a_cnt = cnt; a_amt = amt;
    tick();
  endtask

  task automatic b_cyc(input logic rst, input logic en, input logic ini, input logic wr,
                       input logic [3:0] wv, input logic cnt, input logic [3:0] amt);
    b_rst = rst; b_en = en; b_ini = ini; b_wr = wr; b_wv = wv; b_cnt = cnt; b_amt = amt;
    tick();
  endtask

  initial begin
    a_rst = 1; a_en = 1; a_ini = 0; a_wr = 0; a_wv = 0; a_cnt = 0; a_amt = 0;
    b_rst = 1; b_en = 1; b_ini = 0; b_wr = 0; b_wv = 0; b_cnt = 0; b_amt = 0;
    tick();
    b_rst = 0;
    chk("lit_reset_value", int'(a_value), 255);
    chk("lit_reset_first", int'(a_first), 1);
    chk("lit_reset_expired", int'(a_exp), 0);
    chk("lit_reset_reach", int'(a_reach), 0);

    a_cyc(0, 1, 0, 1, 8'd10, 0, 8'd0);
    a_cyc(0, 1, 1, 0, 8'd0, 0, 8'd0);
    chk("lit_init_value", int'(a_value), 255);
    chk("lit_init_expired", int'(a_exp), 0);

    a_cyc(0, 1, 0, 1, 8'd10, 0, 8'd0);
    a_cyc(0, 1, 0, 0, 8'd0, 1, 8'd3);
    chk("lit_dec_7", int'(a_value), 7);
    a_cyc(0, 1, 0, 0, 8'd0, 1, 8'd3);
    chk("lit_dec_4", int'(a_value), 4);
    a_cyc(0, 1, 0, 0, 8'd0, 1, 8'd3);
    chk("lit_dec_1", int'(a_value), 1);
    a_cyc(0, 1, 0, 0, 8'd0, 1, 8'd3);
    chk("lit_floor_value", int'(a_value), 0);
    chk("lit_floor_reach", int'(a_reach), 1);
    chk("lit_floor_expired", int'(a_exp), 1);
    chk("lit_floor_is_last", int'(a_last), 1);
    a_cyc(0, 1, 0, 0, 8'd0, 0, 8'd3);
    chk("lit_reach_one_cycle", int'(a_reach), 0);

    for (int i = 0; i < 4; i++) begin
      a_cyc(0, 1, 0, 0, 8'd0, 1, 8'd5);
      chk("lit_sat_hold_value", int'(a_value), 0);
      chk("lit_sat_hold_reach", int'(a_reach), 0);
    end
    chk("lit_sat_expired", int'(a_exp), 1);
    a_cyc(0, 1, 0, 1, 8'd20, 0, 8'd0);
    chk("lit_write_clears_expired", int'(a_exp), 0);

    a_cyc(0, 0, 0, 0, 8'd0, 1, 8'd5);
    chk("lit_disable_frozen", int'(a_value), 20);
    a_cyc(0, 1, 1, 1, 8'd77, 1, 8'd5);
    chk("lit_init_beats_write", int'(a_value), 255);
    a_cyc(0, 1, 0, 1, 8'd50, 1, 8'd5);
    chk("lit_write_beats_count", int'(a_value), 50);
    a_cyc(1, 1, 1, 0, 8'd0, 1, 8'd3);
    chk("lit_reset_beats_init", int'(a_value), 255);
    a_cyc(0, 1, 0, 0, 8'd0, 0, 8'd0);

    b_cyc(0, 1, 0, 1, 4'd5, 0, 4'd0);
    b_cyc(0, 1, 0, 0, 4'd0, 1, 4'd15);
    chk("lit_b_no_modular", int'(b_value), 3);
    chk("lit_b_underflow_reach", int'(b_reach), 1);
    b_cyc(0, 1, 0, 1, 4'd5, 0, 4'd0);
    b_cyc(0, 1, 0, 0, 4'd0, 1, 4'd1);
    chk("lit_b_4", int'(b_value), 4);
    b_cyc(0, 1, 0, 0, 4'd0, 1, 4'd1);
    chk("lit_b_3", int'(b_value), 3);
    chk("lit_b_3_reach", int'(b_reach), 1);
    b_cyc(0, 1, 0, 0, 4'd0, 1, 4'd1);
    chk("lit_b_wrap_value", int'(b_value), 9);
    chk("lit_b_wrap_pulse", int'(b_wrap), 1);
    b_cyc(0, 1, 0, 0, 4'd0, 1, 4'd1);
    chk("lit_b_8", int'(b_value), 8);
    chk("lit_b_wrap_gone", int'(b_wrap), 0);
    b_cyc(0, 1, 0, 0, 4'd0, 1, 4'd0);
    chk("lit_b_step0_hold", int'(b_value), 8);

    for (int i = 0; i < 3000; i++) begin
      a_rst = ($urandom_range(0, 63) == 0);
      a_en  = ($urandom_range(0, 7) != 0);
      a_ini = ($urandom_range(0, 31) == 0);
      a_wr  = ($urandom_range(0, 7) == 0);
      a_wv  = 8'($urandom);
      a_cnt = ($urandom_range(0, 3) != 0);
      a_amt = $urandom_range(0, 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      b_rst = ($urandom_range(0, 63) == 0);
      b_en  = ($urandom_range(0, 7) != 0);
      b_ini = ($urandom_range(0, 31) == 0);
      b_wr  = ($urandom_range(0, 7) == 0);
      b_wv  = 4'($urandom);
      b_cnt = ($urandom_range(0, 3) != 0);
      b_amt = 4'($urandom_range(0, 15));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
